// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_FAST_PATH_EN: finish in one cycle when |divisor| > |dividend|.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            annul_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            stallreq_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode at acceptance
    logic            is_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, sgn_ovf, fast_hit;

    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & dividend_i[XLEN-1];
    assign b_neg     = is_signed & divisor_i[XLEN-1];
    assign mag_a     = a_neg ? (XLEN'(0) - dividend_i) : dividend_i;
    assign mag_b     = b_neg ? (XLEN'(0) - divisor_i) : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign sgn_ovf   = is_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
`ifdef DIV_FAST_PATH_EN
    assign fast_hit  = (mag_b > mag_a);
`else
    assign fast_hit  = 1'b0;
`endif

    // One restoring step; the XLEN+1-bit trial keeps the carry out of the shifted remainder
    logic [XLEN:0]   rem_sh, diff;
    logic            trial_ok;
    logic [XLEN-1:0] rem_iter, quo_iter, rem_fin, quo_fin;

    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, dvsr_q};
    assign trial_ok = ~diff[XLEN];
    assign rem_iter = trial_ok ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_iter = {quo_q[XLEN-2:0], trial_ok};
    assign quo_fin  = neg_quo_q ? (XLEN'(0) - quo_iter) : quo_iter;
    assign rem_fin  = neg_rem_q ? (XLEN'(0) - rem_iter) : rem_iter;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    cnt_d     = CNT_W'(XLEN);
                    rem_d     = '0;
                    quo_d     = mag_a;
                    dvsr_d    = mag_b;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    is_rem_d  = op_i[1];
                    if (div_zero) begin
                        result_d = op_i[1] ? dividend_i : '1;
                        state_d  = ST_DONE;
                    end else if (sgn_ovf) begin
                        result_d = op_i[1] ? '0 : dividend_i;
                        state_d  = ST_DONE;
                    end else if (fast_hit) begin
                        result_d = op_i[1] ? dividend_i : '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_iter;
                    quo_d = quo_iter;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_d = is_rem_q ? rem_fin : quo_fin;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            result_q  <= result_d;
        end
    end

    // A flush seen in DONE suppresses the pulse for that op
    assign result_o   = result_q;
    assign valid_o    = (state_q == ST_DONE) && !annul_i;
    assign busy_o     = (state_q != ST_IDLE);
    assign stallreq_o = ((state_q == ST_IDLE) && start_i && !annul_i) ||
                        ((state_q == ST_CALC) && !annul_i);

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage for RV32M DIV/DIVU/REM/REMU.
- Sits directly upstream of the pipeline stall controller. Its stall request output is ORed into that controller's `stallreq_id_ex_i` input.
- That input freezes pc_reg, if_id and id_ex while a division is in flight; ex_mem keeps advancing.
- Stall is released in the cycle the result is presented.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2 and at least 8.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  Core clock; all state updates on rising edge.
- rst  input  1  Reset, synchronous, active-high.
- start_i  input  1  Division instruction present in EX. Held high by the frozen id_ex register throughout the stall.
- op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU. Sampled only at start acceptance.
- dividend_i  input  XLEN  rs1 value. Sampled only at start acceptance.
- divisor_i  input  XLEN  rs2 value. Sampled only at start acceptance.
- annul_i  input  1  Flush of the EX instruction. Aborts any operation in progress.
- result_o  output  XLEN  Quotient or remainder; registered.
- valid_o  output  1  result_o valid; single-cycle pulse.
- busy_o  output  1  High while state != IDLE.
- stallreq_o  output  1  Stall request to the pipeline controller.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, result_o=0, valid_o=0, busy_o=0, stallreq_o=0, counter=0. Internal operand registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and annul_i=0 accepts the operation.
  - Latch |dividend| and |divisor|; magnitudes apply only for DIV/REM, raw values for unsigned ops.
  - Record neg_q = sign(a)^sign(b) and neg_r = sign(a) for signed ops.
  - Clear the partial remainder and load counter=XLEN.
- Special cases at acceptance, both going to DONE next cycle with the result registered:
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = 0x80..0, divisor = all ones, DIV/REM): quotient = dividend; remainder = 0.
- Normal acceptance goes to CALC.
- CALC, one bit per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor at XLEN+1 bits; if non-negative, keep the difference and set the quotient LSB.
  - Decrement the counter.
  - On the cycle counter reaches 1, register the final value into result_o and go to DONE. The quotient is negated if neg_q, the remainder if neg_r (two's complement, XLEN-bit wrap).
- DONE: valid_o=1 for exactly this cycle; result_o is held until the next acceptance. Always returns to IDLE; start_i is ignored in DONE.
- stallreq_o (combinational) = (IDLE & start_i & ~annul_i) | CALC. It is low in DONE, so the pipeline advances at the DONE edge.
- Latency: acceptance edge to valid_o is XLEN+1 cycles for the normal path, 1 cycle for special cases.
- annul_i in CALC or DONE:
  - Next state is IDLE; valid_o is not asserted for the aborted op.
  - result_o is unchanged.
  - stallreq_o drops in the same cycle annul_i is seen.
- rst mid-operation: all state returns to reset values at the next edge, with no output pulse.
- Back-to-back: a new start_i in the IDLE cycle after DONE is accepted normally.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: at acceptance, if |divisor| > |dividend| (unsigned magnitude compare), skip CALC.
  - Quotient = 0; remainder = dividend, original signed value.
  - Go to DONE next cycle with 1-cycle latency, as for the special cases.
- Undefined: these operands take the full XLEN+1 cycle path with identical results.

Test Plan:
- DIVU 100/7, start_i held high:
  - stallreq_o is high in the accept cycle and for 32 CALC cycles.
  - valid_o pulses at cycle 33 with result_o=14.
  - stallreq_o is low in that cycle.
- DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1 (0xFFFFFFFF); REMU 7/0 -> 7; DIVU 5/0 -> 0xFFFFFFFF, with valid_o one cycle after accept.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0, both 1-cycle latency.
- annul_i asserted at CALC cycle 10 of DIVU 1000/3:
  - Unit is IDLE next cycle with stallreq_o=0.
  - No valid_o pulse; result_o keeps its prior value.
- rst at CALC cycle 5 -> all outputs 0 next cycle; a following DIVU 9/3 completes correctly with result 3.
- DIVU 3/10:
  - With DIV_FAST_PATH_EN: valid_o 1 cycle after accept, result 0.
  - Without it: result 0 at cycle 33.
